// File: rtl/tm_avg_unit_if.sv
// Operand/result handshake bundle for the running-average unit.
// The master side issues operands and accepts results; the slave side is the unit.
interface tm_avg_unit_if #(
  parameter int TXLEN_W = 8,
  parameter int EXED_W  = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [TXLEN_W-1:0] avg_in;
  logic [EXED_W-1:0]  exed_in;
  logic [TXLEN_W-1:0] cur_in;
  logic               out_valid;
  logic               out_ready;
  logic [TXLEN_W-1:0] avg_out;
  logic [EXED_W-1:0]  exed_out;
  logic               sat_out;

  modport master (
    output in_valid, avg_in, exed_in, cur_in, out_ready,
    input  in_ready, out_valid, avg_out, exed_out, sat_out
  );

  modport slave (
    input  in_valid, avg_in, exed_in, cur_in, out_ready,
    output in_ready, out_valid, avg_out, exed_out, sat_out
  );
endinterface

// File: rtl/tm_avg_unit.sv
// Running-average unit: floor((avg*exed + cur)/(exed+1)) via a bit-serial restoring
// divider, with a saturating transaction count.
module tm_avg_unit #(
  parameter int TXLEN_W = 8,
  parameter int EXED_W  = 8
) (
  input logic          clk,
  input logic          reset,
  tm_avg_unit_if.slave bus
);
  localparam int NW    = TXLEN_W + EXED_W + 1;
  localparam int DW    = EXED_W + 1;
  localparam int CNT_W = $clog2(NW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } stateT;

  stateT              state;
  stateT              nextState;
  logic [TXLEN_W-1:0] avgOp;
  logic [EXED_W-1:0]  exedOp;
  logic [TXLEN_W-1:0] curOp;
  logic [NW-1:0]      numReg;
  logic [DW-1:0]      denReg;
  logic [DW-1:0]      remReg;
  logic [TXLEN_W-1:0] quotReg;
  logic [CNT_W-1:0]   stepCnt;
  logic [TXLEN_W-1:0] avgOutReg;
  logic [EXED_W-1:0]  exedOutReg;
  logic               satOutReg;
  logic               inReadyReg;
  logic               outValidReg;

  logic [DW:0]        remShift;
  logic [DW-1:0]      remNext;
  logic               quotBit;
  logic [TXLEN_W-1:0] quotNext;
  logic               lastStep;

  // Restoring divider step. The quotient never exceeds max(avg,cur), so only
  // TXLEN_W quotient bits are kept; the bits shifted out are always zero.
  always_comb begin
    remShift = {remReg, numReg[NW-1]};
    if (remShift >= {1'b0, denReg}) begin
      remNext = DW'(remShift - {1'b0, denReg});
      quotBit = 1'b1;
    end else begin
      remNext = remShift[DW-1:0];
      quotBit = 1'b0;
    end
    quotNext = (quotReg << 1) | {{(TXLEN_W-1){1'b0}}, quotBit};
    lastStep = (stepCnt == CNT_W'(NW - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          nextState = LOAD;
        end else begin
          nextState = IDLE;
        end
      end
      LOAD: nextState = DIV;
      DIV: begin
        if (lastStep) begin
          nextState = DONE;
        end else begin
          nextState = DIV;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          nextState = IDLE;
        end else begin
          nextState = DONE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Operand capture, divider datapath and registered handshake/result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avgOp       <= '0;
      exedOp      <= '0;
      curOp       <= '0;
      numReg      <= '0;
      denReg      <= '0;
      remReg      <= '0;
      quotReg     <= '0;
      stepCnt     <= '0;
      avgOutReg   <= '0;
      exedOutReg  <= '0;
      satOutReg   <= 1'b0;
      inReadyReg  <= 1'b1;
      outValidReg <= 1'b0;
    end else begin
      inReadyReg  <= (nextState == IDLE);
      outValidReg <= (nextState == DONE);
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            avgOp  <= bus.avg_in;
            exedOp <= bus.exed_in;
            curOp  <= bus.cur_in;
          end
        end
        LOAD: begin
          // Divisor is one bit wider so a saturated count still divides by 2^EXED_W.
          numReg  <= NW'(avgOp) * NW'(exedOp) + NW'(curOp);
          denReg  <= DW'(exedOp) + DW'(1);
          remReg  <= '0;
          quotReg <= '0;
          stepCnt <= '0;
        end
        DIV: begin
          numReg  <= numReg << 1;
          remReg  <= remNext;
          quotReg <= quotNext;
          stepCnt <= stepCnt + CNT_W'(1);
          if (lastStep) begin
            avgOutReg <= quotNext;
            if (&exedOp) begin
              exedOutReg <= exedOp;
              satOutReg  <= 1'b1;
            end else begin
              exedOutReg <= exedOp + EXED_W'(1);
              satOutReg  <= 1'b0;
            end
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = inReadyReg;
  assign bus.out_valid = outValidReg;
  assign bus.avg_out   = avgOutReg;
  assign bus.exed_out  = exedOutReg;
  assign bus.sat_out   = satOutReg;
endmodule

// File: tb/tb_tm_avg_unit.sv
// Scoreboard bench for tm_avg_unit: the driver queues expected results as operands are
// accepted; a monitor pops and compares at every output handshake.
module tb_tm_avg_unit;
  logic clk;
  logic reset;
  bit   rndReady;
  int   nCmp;
  int   nBad;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] e;
    logic       s;
  } expT;

  expT expQ[$];

  tm_avg_unit_if #(.TXLEN_W(8), .EXED_W(8)) bus ();

  tm_avg_unit #(.TXLEN_W(8), .EXED_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    nCmp++;
    if (act != req) begin
      nBad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare each accepted result against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        expT e;
        e = expQ.pop_front();
        check("avg_out", int'(bus.avg_out), int'(e.a));
        check("exed_out", int'(bus.exed_out), int'(e.e));
        check("sat_out", int'(bus.sat_out), int'(e.s));
      end
    end
  end

  // Random consumer back-pressure.
  always @(posedge clk) begin
    if (rndReady) begin
      #1;
      if (rndReady) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Issue one operand set; caller sits #1 after a rising edge.
  task automatic send(input logic [7:0] a, input logic [7:0] e, input logic [7:0] c,
                      input logic [7:0] ea, input logic [7:0] ee, input logic es,
                      input bit push);
    int  n;
    expT x;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    bus.avg_in   = a;
    bus.exed_in  = e;
    bus.cur_in   = c;
    bus.in_valid = 1'b1;
    if (push) begin
      x.a = ea; x.e = ee; x.s = es;
      expQ.push_back(x);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.avg_in   = 8'hA5;
    bus.exed_in  = 8'h5A;
    bus.cur_in   = 8'h3C;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (expQ.size() != 0) check("drain_timeout", expQ.size(), 0);
    repeat (25) @(posedge clk);
    #1;
  endtask

  logic [7:0] vec [8][6];
  initial begin
    vec[0] = '{8'd200, 8'd0,   8'd7,   8'd7,   8'd1,   8'd0};
    vec[1] = '{8'd100, 8'd255, 8'd255, 8'd100, 8'd255, 8'd1};
    vec[2] = '{8'd255, 8'd254, 8'd255, 8'd255, 8'd255, 8'd0};
    vec[3] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd1,   8'd0};
    vec[4] = '{8'd50,  8'd1,   8'd51,  8'd50,  8'd2,   8'd0};
    vec[5] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd1};
    vec[6] = '{8'd7,   8'd2,   8'd0,   8'd4,   8'd3,   8'd0};
    vec[7] = '{8'd0,   8'd255, 8'd255, 8'd0,   8'd255, 8'd1};
  end

  initial begin
    int k;
    logic [7:0] hA, hE;
    reset        = 1'b1;
    rndReady     = 1'b0;
    nCmp         = 0;
    nBad         = 0;
    bus.in_valid = 1'b0;
    bus.avg_in   = 8'd0;
    bus.exed_in  = 8'd0;
    bus.cur_in   = 8'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_avg_out", int'(bus.avg_out), 0);
    check("rst_exed_out", int'(bus.exed_out), 0);
    check("rst_sat_out", int'(bus.sat_out), 0);

    // Basic average with latency measurement.
    send(8'd10, 8'd3, 8'd30, 8'd15, 8'd4, 1'b0, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, 18);
    drain();

    // Directed table, issued back to back.
    for (int i = 0; i < 8; i++) begin
      send(vec[i][0], vec[i][1], vec[i][2], vec[i][3], vec[i][4], vec[i][5][0], 1'b1);
    end
    drain();

    // Hold in DONE: outputs stable, new operands refused.
    bus.out_ready = 1'b0;
    send(8'd20, 8'd4, 8'd40, 8'd24, 8'd5, 1'b0, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("hold_reach_done", int'(bus.out_valid), 1);
    hA = bus.avg_out;
    hE = bus.exed_out;
    check("hold_avg_value", int'(hA), 24);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.avg_in   = 8'($urandom_range(0, 255));
      bus.exed_in  = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      check("hold_avg_stable", int'(bus.avg_out), int'(hA));
      check("hold_exed_stable", int'(bus.exed_out), int'(hE));
      check("hold_out_valid", int'(bus.out_valid), 1);
      check("hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset in the middle of the divide: aborted, no output.
    send(8'd60, 8'd2, 8'd90, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_avg_out", int'(bus.avg_out), 0);
    check("midrst_exed_out", int'(bus.exed_out), 0);
    check("midrst_sat_out", int'(bus.sat_out), 0);
    @(posedge clk); #1;
    check("midrst_hold_in_ready", int'(bus.in_ready), 1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    send(8'd60, 8'd2, 8'd90, 8'd70, 8'd3, 1'b0, 1'b1);
    drain();

    // Random operands against an arithmetic model, with back-pressure and gaps.
    rndReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int a, e, c, q;
      a = $urandom_range(0, 255);
      c = $urandom_range(0, 255);
      case (i % 4)
        0: e = 0;
        1: e = 254;
        2: e = 255;
        default: e = $urandom_range(0, 255);
      endcase
      q = (a * e + c) / (e + 1);
      send(8'(a), 8'(e), 8'(c), 8'(q), (e == 255) ? 8'd255 : 8'(e + 1), (e == 255), 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    drain();
    rndReady = 1'b0;
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
